// File: rtl/mig_ui_pkg.sv
// Shared UI definitions for the MIG user-interface responder: command codes,
// bus widths, responder state and the read-pipe beat payload.
package mig_ui_pkg;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned CMD_W  = 3;

  localparam logic [CMD_W-1:0] CMD_WRITE = 3'b000;
  localparam logic [CMD_W-1:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    CALIB   = 2'd0,
    RUN     = 2'd1,
    REFRESH = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_beat_t;

  // Merge new data into old per byte; a set mask bit keeps the old byte.
  function automatic logic [DATA_W-1:0] apply_mask(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [MASK_W-1:0] mask
  );
    logic [DATA_W-1:0] res;
    for (int b = 0; b < int'(MASK_W); b++) begin
      res[b*8 +: 8] = mask[b] ? old_w[b*8 +: 8] : new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mig_ui_responder_if.sv
// MIG UI handshake bundle; master = traffic initiator, slave = memory side.
interface mig_ui_responder_if;
  import mig_ui_pkg::*;

  logic [ADDR_W-1:0] app_addr;
  logic [CMD_W-1:0]  app_cmd;
  logic              app_en;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_end;
  logic              app_wdf_wren;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_sr_req;
  logic              app_ref_req;
  logic              app_zq_req;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic              app_sr_active;
  logic              app_ref_ack;
  logic              app_zq_ack;
  logic              init_calib_complete;
  logic              proto_err;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren,
           app_wdf_mask, app_sr_req, app_ref_req, app_zq_req,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           app_sr_active, app_ref_ack, app_zq_ack, init_calib_complete, proto_err
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren,
           app_wdf_mask, app_sr_req, app_ref_req, app_zq_req,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           app_sr_active, app_ref_ack, app_zq_ack, init_calib_complete, proto_err
  );

endinterface

// File: rtl/rd_delay_line.sv
// Fixed-length valid+data shift register carrying read beats to the UI.
module rd_delay_line
  import mig_ui_pkg::*;
#(
  parameter int unsigned STAGES = 3
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  rd_beat_t beat_i,
  output rd_beat_t beat_o
);

  rd_beat_t pipe_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(STAGES); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= beat_i;
      for (int i = 1; i < int'(STAGES); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign beat_o = pipe_q[STAGES-1];

endmodule

// File: rtl/mig_ui_responder.sv
// BRAM-backed stand-in for the MIG UI memory side: calibration delay, refresh
// stalls, bounded read depth and fixed-latency in-order read return.
module mig_ui_responder
  import mig_ui_pkg::*;
#(
  parameter int unsigned DEPTH           = 4096,
  parameter int unsigned RD_LATENCY      = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CALIB_CYCLES    = 16,
  parameter int unsigned REFRESH_PERIOD  = 512,
  parameter int unsigned REFRESH_CYCLES  = 6
) (
  input logic               clk_in,
  input logic               rst_n_in,
  mig_ui_responder_if.slave ui
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WIDX_W = ADDR_W - 3;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned CAL_W  = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned TMR_W  = $clog2(REFRESH_PERIOD + 2);
  localparam int unsigned RCY_W  = $clog2(REFRESH_CYCLES + 1);

  resp_state_e       state_q, state_d;
  logic [CAL_W-1:0]  cal_cnt_q, cal_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [RCY_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic              rdy_q, rdy_d;
  logic              wdf_rdy_q, wdf_rdy_d;
  logic              calib_q, calib_d;
  logic              ref_ack_q, ref_ack_d;
  logic              zq_ack_q, zq_ack_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd0_data_q;
  logic              rd0_valid_q, rd0_oor_q;
  rd_beat_t          rd0_beat, rd_out;

  logic              cmd_hs, is_wr, is_rd, wr_acc, rd_acc, in_range, err_set;
  logic [WIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              unused_ok;

  // Command decode against the registered ready outputs.
  assign cmd_hs   = ui.app_en & rdy_q;
  assign is_wr    = (ui.app_cmd == CMD_WRITE);
  assign is_rd    = (ui.app_cmd == CMD_READ);
  assign wr_acc   = cmd_hs & is_wr & ui.app_wdf_wren & wdf_rdy_q;
  assign rd_acc   = cmd_hs & is_rd;
  assign word_idx = ui.app_addr[ADDR_W-1:3];
  assign in_range = (word_idx < WIDX_W'(DEPTH));
  assign mem_idx  = word_idx[IDX_W-1:0];

  assign err_set = (cmd_hs & (is_wr | is_rd) & (ui.app_addr[2:0] != 3'b000))
                 | (cmd_hs & ~(is_wr | is_rd))
                 | (cmd_hs & is_wr & ~ui.app_wdf_wren)
                 | (ui.app_wdf_wren & wdf_rdy_q & ~(ui.app_en & is_wr))
                 | ((wr_acc | rd_acc) & ~in_range);

  assign unused_ok = &{1'b0, ui.app_wdf_end, ui.app_sr_req};

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= CALIB;
      cal_cnt_q <= '0;
      tmr_q     <= '0;
      ref_cnt_q <= '0;
      outst_q   <= '0;
      rdy_q     <= 1'b0;
      wdf_rdy_q <= 1'b0;
      calib_q   <= 1'b0;
      ref_ack_q <= 1'b0;
      zq_ack_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cal_cnt_q <= cal_cnt_d;
      tmr_q     <= tmr_d;
      ref_cnt_q <= ref_cnt_d;
      outst_q   <= outst_d;
      rdy_q     <= rdy_d;
      wdf_rdy_q <= wdf_rdy_d;
      calib_q   <= calib_d;
      ref_ack_q <= ref_ack_d;
      zq_ack_q  <= zq_ack_d;
      err_q     <= err_d;
    end
  end

  // Next state; the refresh timer keeps running through REFRESH so entries are periodic.
  always_comb begin
    state_d   = state_q;
    cal_cnt_d = cal_cnt_q;
    tmr_d     = tmr_q;
    ref_cnt_d = '0;
    unique case (state_q)
      CALIB: begin
        cal_cnt_d = cal_cnt_q + CAL_W'(1);
        if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (ui.app_ref_req ||
            ((REFRESH_PERIOD != 0) && (tmr_q == TMR_W'(REFRESH_PERIOD - 1)))) begin
          state_d = REFRESH;
          tmr_d   = '0;
        end
      end
      REFRESH: begin
        tmr_d     = tmr_q + TMR_W'(1);
        ref_cnt_d = ref_cnt_q + RCY_W'(1);
        if (ref_cnt_q == RCY_W'(REFRESH_CYCLES - 1)) begin
          state_d   = RUN;
          ref_cnt_d = '0;
        end
      end
      default: state_d = CALIB;
    endcase
  end

  // Output next values, derived from next state so they line up with it.
  always_comb begin
    outst_d = outst_q;
    unique case ({rd_acc, rd_out.valid})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase
    rdy_d     = (state_d == RUN) && (outst_d < OUT_W'(MAX_OUTSTANDING));
    wdf_rdy_d = (state_d == RUN);
    calib_d   = calib_q | (state_d != CALIB);
    ref_ack_d = (state_d == REFRESH) && (ref_cnt_d == RCY_W'(REFRESH_CYCLES - 1));
    zq_ack_d  = ui.app_zq_req;
    err_d     = err_q | err_set;
  end

  // Storage and first read stage; out-of-range words read back as zero.
  always_ff @(posedge clk_in) begin
    if (wr_acc && in_range) begin
      mem[mem_idx] <= apply_mask(mem[mem_idx], ui.app_wdf_data, ui.app_wdf_mask);
    end
    if (rd_acc) rd0_data_q <= mem[mem_idx];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd0_valid_q <= 1'b0;
      rd0_oor_q   <= 1'b0;
    end else begin
      rd0_valid_q <= rd_acc;
      rd0_oor_q   <= rd_acc & ~in_range;
    end
  end

  assign rd0_beat.valid = rd0_valid_q;
  assign rd0_beat.data  = rd0_oor_q ? '0 : rd0_data_q;

  rd_delay_line #(
    .STAGES (RD_LATENCY - 1)
  ) u_rd_delay (
    .clk_i  (clk_in),
    .rst_ni (rst_n_in),
    .beat_i (rd0_beat),
    .beat_o (rd_out)
  );

  assign ui.app_rdy             = rdy_q;
  assign ui.app_wdf_rdy         = wdf_rdy_q;
  assign ui.app_rd_data         = rd_out.data;
  assign ui.app_rd_data_valid   = rd_out.valid;
  assign ui.app_rd_data_end     = rd_out.valid;
  assign ui.app_sr_active       = 1'b0;
  assign ui.app_ref_ack         = ref_ack_q;
  assign ui.app_zq_ack          = zq_ack_q;
  assign ui.init_calib_complete = calib_q;
  assign ui.proto_err           = err_q;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Scoreboard bench for mig_ui_responder: directed commands push expected read
// beats; a negedge monitor pops and checks data and arrival cycle.
module tb_mig_ui_responder;
  import mig_ui_pkg::*;

  localparam int unsigned LAT  = 4;
  localparam int unsigned MAXO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mig_ui_responder_if ui ();

  mig_ui_responder #(
    .DEPTH           (4096),
    .RD_LATENCY      (LAT),
    .MAX_OUTSTANDING (MAXO),
    .CALIB_CYCLES    (16),
    .REFRESH_PERIOD  (32),
    .REFRESH_CYCLES  (6)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .ui       (ui)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [DATA_W-1:0] exp_data_q [$];
  int                exp_cyc_q  [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && ui.app_rd_data_valid) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid at cycle %0d expected none", cyc);
      end else begin
        check("rd_data", ui.app_rd_data, exp_data_q.pop_front());
        check("rd_cycle", DATA_W'(cyc), DATA_W'(exp_cyc_q.pop_front()));
        check("rd_end", DATA_W'(ui.app_rd_data_end), DATA_W'(1));
      end
    end
  end

  task automatic idle();
    ui.app_en       = 1'b0;
    ui.app_wdf_wren = 1'b0;
    ui.app_wdf_end  = 1'b0;
  endtask

  // Present a command at the current negedge and hold it until app_rdy is seen.
  task automatic do_cmd(input logic [2:0] cmd, input logic [26:0] addr,
                        input logic [127:0] wdata, input logic [15:0] mask,
                        input logic wren, input logic [127:0] exp, output int waits);
    ui.app_en       = 1'b1;
    ui.app_cmd      = cmd;
    ui.app_addr     = addr;
    ui.app_wdf_data = wdata;
    ui.app_wdf_mask = mask;
    ui.app_wdf_wren = wren;
    ui.app_wdf_end  = wren;
    waits = 0;
    while (!ui.app_rdy && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!ui.app_rdy) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: got app_rdy=0 for 200 cycles expected 1");
    end else if (cmd == CMD_READ) begin
      exp_data_q.push_back(exp);
      exp_cyc_q.push_back(cyc + int'(LAT));
    end
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
    int w;
    do_cmd(CMD_WRITE, a, d, m, 1'b1, '0, w);
  endtask

  task automatic rd(input logic [26:0] a, input logic [127:0] e, output int w);
    do_cmd(CMD_READ, a, '0, '0, 1'b0, e, w);
  endtask

  task automatic wait_ref_ack();
    int t = 0;
    while (!ui.app_ref_ack && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ui.app_ref_ack) begin
      checks++;
      errors++;
      $display("FAIL ref_ack_timeout: got no app_ref_ack in 100 cycles expected pulse");
    end
  endtask

  task automatic reset_dut();
    int t = 0;
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    exp_data_q.delete();
    exp_cyc_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    while (!ui.init_calib_complete && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("calib_after_reset", DATA_W'(ui.init_calib_complete), DATA_W'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int nvalid;
    ui.app_addr = '0; ui.app_cmd = '0; ui.app_en = 1'b0;
    ui.app_wdf_data = '0; ui.app_wdf_end = 1'b0; ui.app_wdf_wren = 1'b0;
    ui.app_wdf_mask = '0; ui.app_sr_req = 1'b0; ui.app_ref_req = 1'b0;
    ui.app_zq_req = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_rdy", DATA_W'(ui.app_rdy), DATA_W'(0));
    check("rst_calib", DATA_W'(ui.init_calib_complete), DATA_W'(0));
    check("rst_valid", DATA_W'(ui.app_rd_data_valid), DATA_W'(0));
    check("rst_err", DATA_W'(ui.proto_err), DATA_W'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Calibration: a read held on the bus before cycle 16 must not be taken.
    ui.app_en = 1'b1; ui.app_cmd = CMD_READ; ui.app_addr = '0;
    for (int k = 0; k < 18; k++) begin
      check("calib_rdy", DATA_W'(ui.app_rdy), DATA_W'(k >= 16));
      check("calib_done", DATA_W'(ui.init_calib_complete), DATA_W'(k >= 16));
      if (k == 15) idle();
      @(negedge clk);
    end
    check("calib_err", DATA_W'(ui.proto_err), DATA_W'(0));

    for (int i = 0; i < 8; i++) wr(27'(i * 8), 128'(i), 16'h0000);

    // Back-to-back reads right after a refresh; depth 4 holds the 5th read one cycle.
    wait_ref_ack();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rd(27'(i * 8), 128'(i), w);
      check("bp_wait", DATA_W'(w), DATA_W'(i == 4 ? 1 : 0));
    end

    wr(27'h10, '0, 16'h0000);
    wr(27'h10, '1, 16'h00FF);
    rd(27'h10, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, w);
    wr(27'h18, '1, 16'hFFFE);
    rd(27'h18, 128'hFF, w);

    // Refresh cadence: 26 ready cycles, then 6 stalled, ack in the last.
    wait_ref_ack();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      check("ref_rdy", DATA_W'(ui.app_rdy), DATA_W'(k <= 26));
      check("ref_ack", DATA_W'(ui.app_ref_ack), DATA_W'(k == 32));
    end
    repeat (21) @(negedge clk);
    for (int i = 0; i < 8; i++) rd(27'h28, 128'd5, w);

    @(negedge clk);
    ui.app_zq_req = 1'b1;
    @(negedge clk);
    ui.app_zq_req = 1'b0;
    check("zq_ack_hi", DATA_W'(ui.app_zq_ack), DATA_W'(1));
    @(negedge clk);
    check("zq_ack_lo", DATA_W'(ui.app_zq_ack), DATA_W'(0));
    check("sr_active", DATA_W'(ui.app_sr_active), DATA_W'(0));
    check("err_clean", DATA_W'(ui.proto_err), DATA_W'(0));

    rd(27'h5, '0, w);
    repeat (LAT + 2) @(negedge clk);
    check("err_misalign", DATA_W'(ui.proto_err), DATA_W'(1));

    reset_dut();
    check("err_after_reset", DATA_W'(ui.proto_err), DATA_W'(0));
    rd(27'(4096 * 8), '0, w);
    rd(27'(4097 * 8), '0, w);
    repeat (LAT + 2) @(negedge clk);
    check("err_range", DATA_W'(ui.proto_err), DATA_W'(1));

    reset_dut();
    do_cmd(3'b010, 27'h0, '0, '0, 1'b0, '0, w);
    check("err_illegal", DATA_W'(ui.proto_err), DATA_W'(1));

    reset_dut();
    ui.app_wdf_wren = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    check("err_stray_wren", DATA_W'(ui.proto_err), DATA_W'(1));

    // Async reset with reads in flight: outputs clear at once, nothing returns later.
    wait_ref_ack();
    @(negedge clk);
    rd(27'h00, 128'd0, w);
    rd(27'h08, 128'd1, w);
    rd(27'h20, 128'd4, w);
    @(posedge clk);
    #1;
    check("pre_rst_valid", DATA_W'(ui.app_rd_data_valid), DATA_W'(1));
    #1 rst_n = 1'b0;
    #1;
    exp_data_q.delete();
    exp_cyc_q.delete();
    check("arst_valid", DATA_W'(ui.app_rd_data_valid), DATA_W'(0));
    check("arst_data", ui.app_rd_data, '0);
    check("arst_rdy", DATA_W'(ui.app_rdy), DATA_W'(0));
    check("arst_wdf_rdy", DATA_W'(ui.app_wdf_rdy), DATA_W'(0));
    check("arst_calib", DATA_W'(ui.init_calib_complete), DATA_W'(0));
    check("arst_err", DATA_W'(ui.proto_err), DATA_W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ui.app_rd_data_valid) nvalid++;
    end
    check("post_rst_valids", DATA_W'(nvalid), DATA_W'(0));

    check("sb_empty", DATA_W'(exp_data_q.size()), DATA_W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
